mod_accumulator: RTL and testbench
==================================

Name: mod_accumulator

Overview:
- Sequential modular summation unit. Consumes a stream of field elements and produces their sum mod p.
- Sits directly downstream of the modular adder and reduction stages in the MSM bucket-accumulation path. Each bucket's partial terms are folded into one reduced residue that the point-arithmetic stage consumes.
- Reduction is a single conditional subtraction per term. This works because both operands are kept strictly below p.

Parameters:
- p, 37, field modulus; must satisfy 2 <= p < 2^width.
- width, 128, bit width of data inputs and result.
- cnt_width, 16, bit width of the term-count input.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a new accumulation; sampled only in IDLE.
- num_terms  input  cnt_width  number of terms to accumulate; sampled with start.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a term this cycle.
- in_data  input  width  term to add; expected < p.
- out_valid  output  1  result is valid; held until taken.
- out_ready  input  1  consumer takes the result.
- result  output  width  accumulated sum mod p.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky flag: an out-of-range term (>= p) was received since the last start.

Behaviour:
- Reset (asynchronous, active-high), all outputs registered:
  - state=IDLE; acc=0; count=0; result=0.
  - in_ready=0, out_valid=0, busy=0, err=0.
  - Reset asserted mid-operation aborts immediately; no result is produced.
- IDLE:
  - On start=1 with num_terms=0: go to DONE with acc=0.
  - On start=1 with num_terms>0: acc<=0, count<=num_terms, err<=0, go to WAIT_IN.
  - start while not in IDLE is ignored.
- WAIT_IN:
  - in_ready=1.
  - A transfer happens when in_valid && in_ready.
  - On transfer: sum <= acc + t, computed at width+1 bits so it never overflows. t=in_data if in_data<p; otherwise t=0 and err<=1. Go to REDUCE.
  - No transfer: stay.
- REDUCE:
  - in_ready=0.
  - acc <= (sum >= p) ? sum - p : sum. The result is always < p.
  - count <= count-1.
  - If count==1, go to DONE; otherwise go to WAIT_IN.
- DONE:
  - result=acc; out_valid=1.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - result holds its value after the handoff until the next DONE.
- Throughput and latency:
  - At most one term every 2 cycles.
  - out_valid rises 1 cycle after the REDUCE of the last term.
  - For N back-to-back terms, out_valid rises 2N+1 cycles after start.
- Boundary cases:
  - sum == p exactly reduces to 0.
  - Maximum sum is 2p-2, so one subtraction is always sufficient.
  - num_terms = 2^cnt_width-1 must work without count wrap.
  - in_valid held high across terms is consumed at the 2-cycle cadence. Data must stay stable while in_valid=1 && in_ready=0.
  - out_ready asserted before DONE has no effect.

Decomposition:
- Shared package mod_arith_pkg:
  - State enum: IDLE, WAIT_IN, REDUCE, DONE.
  - Helper constant for width+1 sum sizing.
- One natural sub-module: mod_cond_sub.
  - Combinational: input a of width+1 bits; output (a >= p ? a-p : a) truncated to width.
  - Parameterised by p and width; reusable by the subtraction stage.
- The FSM, counter and acc register live in the top module.

Test Plan:
- Basic sum: p=37; start with num_terms=3; terms 30, 20, 10 -> sum 60 mod 37, so result=23, out_valid rises 7 cycles after start, err=0.
- Exact-modulus wrap: terms 36, 1 -> result=0. Terms 36, 36 -> result=35.
- Zero terms: start with num_terms=0 -> out_valid next cycle, result=0, no in_ready pulse.
- Backpressure and stalls:
  - in_valid toggled randomly and out_ready held low for 5 cycles; terms 5, 6, 7.
  - Expected: result=18, held stable with out_valid=1 until out_ready; start pulses during busy are ignored.
- Out-of-range term: terms 10, 40, 3 -> result=13, err=1. err clears on the next start.
- Reset mid-run:
  - Assert reset after 2 of 4 terms -> all outputs 0 immediately.
  - Then a new start with terms 1, 2 -> result=3.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// -----------------------------------------------------------------------------
// mod_arith_pkg
// Shared definitions for the modular-arithmetic accumulation path.
//   state_t        : accumulator control states (IDLE, WAIT_IN, REDUCE, DONE)
//   SUM_GUARD_BITS : extra bits carried above the data width for acc + term
//   sum_width()    : width of an unreduced sum for a given data width
// -----------------------------------------------------------------------------
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        REDUCE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Both addends are kept below p, so their sum is at most 2p-2 and one
    // guard bit above the data width is enough to hold it without overflow.
    localparam int SUM_GUARD_BITS = 1;

    function automatic int sum_width(input int data_width);
        return data_width + SUM_GUARD_BITS;
    endfunction

endpackage

// File: rtl/mod_cond_sub.sv
// -----------------------------------------------------------------------------
// mod_cond_sub
// Combinational single-step modular reduction: y = (a >= p) ? a - p : a.
// Valid whenever a < 2p, which holds for the sum of two residues.
//   a : unreduced sum, WIDTH+1 bits
//   y : reduced residue, WIDTH bits, always < p
// -----------------------------------------------------------------------------
module mod_cond_sub
    import mod_arith_pkg::*;
#(
    parameter int               WIDTH = 128,
    parameter logic [WIDTH-1:0] P     = 37
) (
    input  logic [sum_width(WIDTH)-1:0] a,
    output logic [WIDTH-1:0]            y
);

    localparam logic [sum_width(WIDTH)-1:0] P_EXT = {{SUM_GUARD_BITS{1'b0}}, P};

    // The selected value is below p, so dropping the guard bit loses nothing.
    assign y = WIDTH'((a >= P_EXT) ? (a - P_EXT) : a);

endmodule

// File: rtl/mod_accumulator.sv
// -----------------------------------------------------------------------------
// mod_accumulator
// Sequential modular summation: folds num_terms field elements into one
// residue mod p, one term every two cycles (accept, then reduce).
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   start, num_terms    : begin a job of num_terms terms (sampled in IDLE only)
//   in_valid/in_ready   : term handshake, in_data is the term (expected < p)
//   out_valid/out_ready : result handshake, result held until taken and after
//   busy                : high in every state except IDLE
//   err                 : sticky, a term >= p was seen since the last start
// All outputs are registered.
// -----------------------------------------------------------------------------
module mod_accumulator
    import mod_arith_pkg::*;
#(
    parameter int               WIDTH     = 128,
    parameter logic [WIDTH-1:0] P         = 37,
    parameter int               CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_terms,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 err
);

    localparam int SUM_W = sum_width(WIDTH);

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [SUM_W-1:0]     r_sum;
    logic [CNT_WIDTH-1:0] r_count;
    logic [WIDTH-1:0]     r_result;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_err;

    logic                 w_transfer;
    logic                 w_in_range;
    logic [SUM_W-1:0]     w_addend;
    logic [WIDTH-1:0]     w_reduced;

    assign w_transfer = in_valid && r_in_ready;
    assign w_in_range = (in_data < P);
    // An out-of-range term contributes nothing so acc stays a valid residue.
    assign w_addend   = w_in_range ? {{SUM_GUARD_BITS{1'b0}}, in_data} : '0;

    mod_cond_sub #(
        .WIDTH (WIDTH),
        .P     (P)
    ) u_cond_sub (
        .a (r_sum),
        .y (w_reduced)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (num_terms == '0) begin
                            r_result    <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_count    <= num_terms;
                            r_in_ready <= 1'b1;
                            r_state    <= WAIT_IN;
                        end
                    end
                end

                WAIT_IN: begin
                    if (w_transfer) begin
                        r_sum      <= {{SUM_GUARD_BITS{1'b0}}, r_acc} + w_addend;
                        r_in_ready <= 1'b0;
                        r_state    <= REDUCE;
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                REDUCE: begin
                    r_acc   <= w_reduced;
                    r_count <= r_count - CNT_WIDTH'(1);
                    // Count down to 1 rather than 0 so a full-scale num_terms
                    // never needs a wrap or an extra terminal state.
                    if (r_count == CNT_WIDTH'(1)) begin
                        r_result    <= w_reduced;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= WAIT_IN;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_mod_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mod_accumulator
// Self-checking bench for mod_accumulator (p = 37, width = 128, cnt_width = 16).
// Expected results come from a reference that simply sums the in-range terms of
// a job and takes the remainder mod p.
// -----------------------------------------------------------------------------
module tb_mod_accumulator;

    localparam int               W  = 128;
    localparam int               CW = 16;
    localparam logic [W-1:0]     P  = 37;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_terms;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          busy;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] job_q[$];

    always #5 clk = ~clk;

    mod_accumulator #(
        .WIDTH     (W),
        .P         (P),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_terms (num_terms),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        job_q.push_back(v);
    endtask

    // Runs the job held in job_q and checks the outcome against the reference.
    //   rand_valid : randomly drop in_valid instead of holding it high
    //   poke       : pulse start / out_ready randomly while the job is busy
    //   hold       : cycles to keep out_ready low once the result is up
    task automatic run_job(input string tag, input bit rand_valid, input bit poke,
                           input int hold);
        int           n;
        int           idx;
        int           cyc;
        int           budget;
        bit           saw_ready;
        bit           xfer;
        bit           exp_err;
        logic [W:0]   total;
        logic [W-1:0] exp_res;

        n         = job_q.size();
        idx       = 0;
        budget    = 8 * n + 20;
        saw_ready = 1'b0;
        exp_err   = 1'b0;
        total     = '0;
        foreach (job_q[i]) begin
            if (job_q[i] < P) total += {1'b0, job_q[i]};
            else              exp_err = 1'b1;
        end
        exp_res = W'(total % {1'b0, P});

        start     = 1'b1;
        num_terms = CW'(n);
        out_ready = 1'b0;
        step();
        start = 1'b0;
        cyc   = 1;

        while (!out_valid && cyc < budget) begin
            if (in_ready) saw_ready = 1'b1;
            in_valid = (idx < n) && (!rand_valid || $urandom_range(0, 1) == 1);
            in_data  = (idx < n) ? job_q[idx] : '0;
            if (poke) begin
                start     = ($urandom_range(0, 1) == 1);
                num_terms = CW'($urandom_range(0, 5));
                out_ready = ($urandom_range(0, 1) == 1);
            end
            xfer = in_valid && in_ready;
            step();
            cyc++;
            if (xfer) idx++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        check({tag, " out_valid"}, W'(out_valid), W'(1));
        if (!rand_valid) check({tag, " latency"}, W'(cyc), W'(2 * n + 1));
        check({tag, " consumed"}, W'(idx), W'(n));
        check({tag, " result"}, result, exp_res);
        check({tag, " err"}, W'(err), W'(exp_err));
        check({tag, " busy"}, W'(busy), W'(1));
        check({tag, " in_ready_done"}, W'(in_ready), W'(0));
        if (n == 0) check({tag, " no_ready_pulse"}, W'(saw_ready), W'(0));

        repeat (hold) step();
        if (hold > 0) begin
            check({tag, " held_valid"}, W'(out_valid), W'(1));
            check({tag, " held_result"}, result, exp_res);
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " taken"}, W'(out_valid), W'(0));
        check({tag, " idle"}, W'(busy), W'(0));
        check({tag, " result_kept"}, result, exp_res);
        step();
    endtask

    initial begin
        int guard;

        reset     = 1'b1;
        start     = 1'b0;
        num_terms = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst result", result, '0);
        check("rst out_valid", W'(out_valid), W'(0));
        check("rst in_ready", W'(in_ready), W'(0));
        check("rst busy", W'(busy), W'(0));
        check("rst err", W'(err), W'(0));
        step();
        reset = 1'b0;
        step();

        job_q.delete(); push(30); push(20); push(10);
        run_job("basic", 1'b0, 1'b0, 0);

        job_q.delete(); push(36); push(1);
        run_job("wrap_exact", 1'b0, 1'b0, 0);

        job_q.delete(); push(36); push(36);
        run_job("wrap_max", 1'b0, 1'b0, 0);

        job_q.delete();
        run_job("zero_terms", 1'b0, 1'b0, 0);

        job_q.delete(); push(5); push(6); push(7);
        run_job("backpressure", 1'b1, 1'b1, 5);

        job_q.delete(); push(10); push(40); push(3);
        run_job("out_of_range", 1'b0, 1'b0, 2);

        job_q.delete(); push(4);
        run_job("err_cleared", 1'b0, 1'b0, 0);

        // Abort a 4-term job after two accepted terms; the first term is out of
        // range so err is known high when reset hits.
        job_q.delete(); push(50); push(2); push(3); push(4);
        start     = 1'b1;
        num_terms = CW'(4);
        step();
        start = 1'b0;
        guard = 0;
        while (job_q.size() > 2 && guard < 40) begin
            in_valid = 1'b1;
            in_data  = job_q[0];
            if (in_ready) begin
                step();
                void'(job_q.pop_front());
            end else begin
                step();
            end
            guard++;
        end
        in_valid = 1'b0;
        check("abort accepted_two", W'(job_q.size()), W'(2));
        check("abort err_before", W'(err), W'(1));
        check("abort busy_before", W'(busy), W'(1));
        #2 reset = 1'b1;
        #1;
        check("abort result", result, '0);
        check("abort out_valid", W'(out_valid), W'(0));
        check("abort in_ready", W'(in_ready), W'(0));
        check("abort busy", W'(busy), W'(0));
        check("abort err", W'(err), W'(0));
        step();
        reset = 1'b0;
        step();

        job_q.delete(); push(1); push(2);
        run_job("after_reset", 1'b0, 1'b0, 0);

        repeat (25) begin
            int n;
            int r;
            n = $urandom_range(0, 6);
            job_q.delete();
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      push({$urandom, $urandom, $urandom, $urandom});
                else if (r == 1) push(P);
                else if (r == 2) push(P - 1);
                else             push(W'($urandom_range(0, 36)));
            end
            run_job("random", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
